hdmi_timing_gen: RTL
====================

# hdmi_timing_gen

Pixel-rate video timing and test-pattern source that drives the HDMI transmit path. It generates 640x480@60 raster timing (hsync, vsync, de) from horizontal/vertical counters, plus a selectable 24-bit RGB test pattern. All outputs are registered and mutually aligned, so they feed the TMDS encoder inputs of `hdmi_ctrl` directly.

## Interface
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch
- `H_VALID`, 640, active pixels per line (multiple of 8)
- `H_FRONT`, 16, horizontal front porch
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch
- `V_VALID`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `vga_clk  in  1  pixel clock; one clock domain, all logic on rising edge`
- `sys_rst_n  in  1  reset, asynchronous, active-low`
- `pat_sel  in  2  pattern select; sampled only at frame start`
- `hsync  out  1  active-high during the horizontal sync region`
- `vsync  out  1  active-high during the vertical sync region`
- `de  out  1  high inside the active region`
- `pix_x  out  10  active-region column, 0..H_VALID-1; 0 when de=0`
- `pix_y  out  10  active-region row, 0..V_VALID-1; 0 when de=0`
- `rgb_red, rgb_green, rgb_blue  out  8 each  pixel colour; 0 when de=0`
- `frame_start  out  1  one-cycle pulse on the first output cycle of each frame`

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Line and frame order: sync, back porch, active, front porch.
- `cnt_h` counts 0..H_TOTAL-1 and wraps to 0.
- `cnt_v` increments when `cnt_h` = H_TOTAL-1, and wraps to 0 after V_TOTAL-1.
- Sync and active decodes:
  - hsync = (`cnt_h` < H_SYNC).
  - vsync = (`cnt_v` < V_SYNC).
  - de = (H_SYNC+H_BACK ≤ `cnt_h` < H_SYNC+H_BACK+H_VALID) AND (V_SYNC+V_BACK ≤ `cnt_v` < V_SYNC+V_BACK+V_VALID).
- Coordinates: pix_x = `cnt_h` − (H_SYNC+H_BACK); pix_y = `cnt_v` − (V_SYNC+V_BACK); both are forced to 0 outside the active region.
- Frame-start event: when `cnt_h`=0 and `cnt_v`=0:
  - `pat_sel` is latched into `pat_q`;
  - the 8-bit `frame_cnt` increments, wrapping 255→0.
- A `pat_sel` change mid-frame has no effect until the next frame start.
- Pattern by `pat_q`:
  - 0: 8 vertical bars, each H_VALID/8 (80) wide, left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 1: grey ramp; R=G=B=pix_x[9:2].
  - 2: 32x32 checkerboard; white when pix_x[5]^pix_y[5]=1, otherwise black.
  - 3: full-screen solid colour, using the bar colour at index `frame_cnt`[7:5]; the colour changes every 32 frames.
- Reset while asserted:
  - counters, `pat_q` and `frame_cnt` are 0;
  - all outputs are 0.
- Reset mid-frame aborts the frame immediately (asynchronous clear). On release the raster restarts from `cnt_h`=`cnt_v`=0.

## Timing
- Single registered stage: the outputs at edge n+1 reflect the counter state at edge n. hsync, vsync, de, pix_x, pix_y, rgb_* and frame_start are all cycle-aligned; no output has extra skew.
- First edge after reset release: counters advance to `cnt_h`=1, and outputs show the decode of `cnt_h`=0.
  - On that edge: hsync=1, vsync=1, frame_start=1, and `pat_q` takes `pat_sel`.
- Positions relative to the frame_start cycle (cycle 0):
  - hsync is high for cycles 0..95 of each 800-cycle line;
  - vsync is high for cycles 0..1599;
  - de first rises at cycle 35·800+144 = 28144 and stays high for 640 consecutive cycles per active line;
  - the next frame_start is at cycle 420000.
- The pattern latched at frame start applies to every pixel of that frame, including pixel (0,0).
- Pattern decode is combinational from the pre-register coordinates, so colour adds no latency beyond the single output register.

## Test plan
- Reset values: hold `sys_rst_n`=0 for 10 cycles → all outputs 0. After release, the first edge gives hsync=vsync=frame_start=1, de=0.
- Line/frame timing over 2 frames:
  - hsync period 800 with high time 96;
  - vsync high 1600 cycles per 420000;
  - de high exactly 307200 cycles per frame, first at cycle 28144;
  - frame_start spacing 420000.
- Colour bars, `pat_sel`=0: on row 0, pix_x=79 → FFFFFF; pix_x=80 → FFFF00; pix_x=639 → 000000; the cycle after the last active pixel → de=0 and rgb=0.
- Pattern latching: start with `pat_sel`=0, switch to 2 mid-frame → bars continue to the end of the frame. In the next frame, pixel (32,0) is white and pixel (0,0) is black.
- Ramp and solid patterns:
  - `pat_sel`=1: pix_x=400 → R=G=B=100.
  - `pat_sel`=3: the frame with `frame_cnt`=32 is solid yellow FFFF00.
- Reset mid-frame: assert `sys_rst_n`=0 at pix (300,200) → outputs clear asynchronously (same cycle). On release, frame_start pulses and de rises again exactly 28144 cycles later.

Source files
------------

// File: rtl/hdmi_timing_gen_if.sv
// rtl/hdmi_timing_gen_if.sv - video timing/pattern bundle between the timing generator and the TMDS path
interface hdmi_timing_gen_if;
    logic [1:0] pat_sel;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] rgb_red;
    logic [7:0] rgb_green;
    logic [7:0] rgb_blue;
    logic       frame_start;

    modport master (
        input  pat_sel,
        output hsync, vsync, de, pix_x, pix_y,
        output rgb_red, rgb_green, rgb_blue, frame_start
    );

    modport slave (
        output pat_sel,
        input  hsync, vsync, de, pix_x, pix_y,
        input  rgb_red, rgb_green, rgb_blue, frame_start
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// rtl/hdmi_timing_gen.sv - raster timing counters plus test-pattern source, one output register stage
module hdmi_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic              vga_clk_i,
    input  logic              sys_rst_n_i,
    hdmi_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int BAR_W   = H_VALID / 8;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI   = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI   = 10'(V_SYNC + V_BACK + V_VALID);

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  bar_idx;
    logic        frame_evt;

    always_comb begin
        cnt_h_d = (cnt_h_q == H_LAST) ? '0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 10'd1;
        end

        frame_evt   = (cnt_h_q == '0) && (cnt_v_q == '0);
        pat_d       = frame_evt ? vid.pat_sel : pat_q;
        frame_cnt_d = frame_evt ? frame_cnt_q + 8'd1 : frame_cnt_q;
        fs_d        = frame_evt;

        hsync_d = (cnt_h_q < H_SYNC_END);
        vsync_d = (cnt_v_q < V_SYNC_END);
        de_d    = (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI) &&
                  (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
        pix_x_d = de_d ? cnt_h_q - H_ACT_LO : '0;
        pix_y_d = de_d ? cnt_v_q - V_ACT_LO : '0;

        // Threshold chain instead of a divide by the (non power-of-two) bar width.
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (int'(pix_x_d) >= i * BAR_W) bar_idx = 3'(i);
        end

        // pat_q only changes on the frame_evt cycle, which is never active video.
        case (pat_q)
            2'd0:    rgb_d = bar_colour(bar_idx);
            2'd1:    rgb_d = {3{pix_x_d[9:2]}};
            2'd2:    rgb_d = (pix_x_d[5] ^ pix_y_d[5]) ? 24'hFFFFFF : 24'h000000;
            default: rgb_d = bar_colour(frame_cnt_q[7:5]);
        endcase
        if (!de_d) rgb_d = '0;
    end

    always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            cnt_h_q     <= '0;
            cnt_v_q     <= '0;
            pat_q       <= '0;
            frame_cnt_q <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            rgb_q       <= '0;
        end else begin
            cnt_h_q     <= cnt_h_d;
            cnt_v_q     <= cnt_v_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            rgb_q       <= rgb_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.frame_start = fs_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.rgb_red     = rgb_q[23:16];
    assign vid.rgb_green   = rgb_q[15:8];
    assign vid.rgb_blue    = rgb_q[7:0];
endmodule
